// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester round-robin arbiter and sequencer for the shared ALU.
//   Each cycle it picks at most one valid request and steers that
//   requester's operands and control code to the ALU. The combinational ALU
//   result and flags are then captured into a one-deep response register
//   that supports backpressure. The block also holds the architectural NZCV
//   flags register, which only ADDS and SUBS update.
//
// Ports
//   clk                        rising-edge clock
//   reset                      asynchronous active-low reset
//   req0_*/req1_*              valid/ready request channels: a, b, ctrl payload
//   alu_a, alu_b, alu_ctrl     operands and control code driven to the ALU
//   alu_result, alu_n..alu_v   combinational ALU result and flag outputs
//   rsp_valid/rsp_ready        response handshake
//   rsp_id                     requester that issued the response
//   rsp_result, rsp_flags      registered result and {N,Z,C,V}
//   rsp_err                    set when the control code was illegal
//   flags                      architectural {N,Z,C,V} register
module alu_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [3:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [3:0]   req1_ctrl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_result,
    input  logic         alu_n,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic [3:0]   flags
);

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t   state_reg, state_next;
    logic         last_grant_reg;
    logic         rsp_id_reg;
    logic [W-1:0] rsp_result_reg;
    logic [3:0]   rsp_flags_reg;
    logic         rsp_err_reg;
    logic [3:0]   flags_reg;

    logic         grant_valid;
    logic         grant_id;
    logic         can_accept;
    logic         accept;
    logic         illegal;
    logic         sets_flags;

    // Grant depends only on the valids and the round-robin pointer, never on
    // the payload, so ready cannot combinationally loop through the ALU.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_reg;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign can_accept = (state_reg == RSP_EMPTY) | rsp_ready;
    assign accept     = grant_valid & can_accept;
    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;

    // With no grant grant_id is 0, so requester 0's payload is presented.
    assign alu_a    = grant_id ? req1_a    : req0_a;
    assign alu_b    = grant_id ? req1_b    : req0_b;
    assign alu_ctrl = grant_id ? req1_ctrl : req0_ctrl;

    always_comb begin
        illegal = 1'b1;
        case (alu_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1010, 4'b1110: illegal = 1'b0;
            default:                   illegal = 1'b1;
        endcase
    end

    // Only ADDS and SUBS write the flags; illegal codes with bit 3 set must not.
    assign sets_flags = (alu_ctrl == 4'b1010) || (alu_ctrl == 4'b1110);

    // Response register occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RSP_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RSP_EMPTY: begin
                if (accept) begin
                    state_next = RSP_FULL;
                end
            end
            RSP_FULL: begin
                // An accept while FULL implies rsp_ready: reload and stay FULL.
                if (rsp_ready && !accept) begin
                    state_next = RSP_EMPTY;
                end
            end
            default: state_next = RSP_EMPTY;
        endcase
    end

    // Response payload, round-robin pointer and architectural flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= 1'b1;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= 4'b0000;
            rsp_err_reg    <= 1'b0;
            flags_reg      <= 4'b0000;
        end else if (accept) begin
            last_grant_reg <= grant_id;
            rsp_id_reg     <= grant_id;
            rsp_result_reg <= alu_result;
            rsp_flags_reg  <= {alu_n, alu_z, alu_c, alu_v};
            rsp_err_reg    <= illegal;
            if (sets_flags) begin
                flags_reg <= {alu_n, alu_z, alu_c, alu_v};
            end
        end
    end

    assign rsp_valid  = (state_reg == RSP_FULL);
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_flags  = rsp_flags_reg;
    assign rsp_err    = rsp_err_reg;
    assign flags      = flags_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. It includes a behavioural 64-bit ALU
//   (carry is borrow on subtract). Table vectors are applied one per cycle,
//   and expected responses are queued in a scoreboard at accept time.
//   Hand-written sequences cover round-robin, backpressure and async reset.
module tb_alu_arbiter;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_ctrl, req1_ctrl;
    logic [W-1:0] alu_a, alu_b;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         alu_n, alu_z, alu_c, alu_v;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags, flags;

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    logic [W:0] alu_wide;
    always_comb begin
        alu_wide   = '0;
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_b;
            4'b0010, 4'b1010: begin
                alu_wide   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = alu_wide[W-1:0];
                alu_c      = alu_wide[W];
                alu_v      = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            4'b0110, 4'b1110: begin
                alu_result = alu_a - alu_b;
                alu_c      = (alu_a < alu_b);
                alu_v      = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            default: alu_result = '0;
        endcase
        alu_n = alu_result[W-1];
        alu_z = (alu_result == '0);
    end

    typedef struct {
        logic         v0;
        logic [3:0]   c0;
        logic [W-1:0] a0, b0;
        logic         v1;
        logic [3:0]   c1;
        logic [W-1:0] a1, b1;
        logic         er0, er1;
        logic [W-1:0] eres;
        logic [3:0]   eflg;
        logic         eerr;
        logic [3:0]   eflags;
    } vec_t;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         err;
    } rsp_t;

    vec_t vecs[11];
    rsp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_txn   = 0;

    function automatic vec_t mk(logic v0, logic [3:0] c0, logic [W-1:0] a0, logic [W-1:0] b0,
                                logic v1, logic [3:0] c1, logic [W-1:0] a1, logic [W-1:0] b1,
                                logic er0, logic er1, logic [W-1:0] eres, logic [3:0] eflg,
                                logic eerr, logic [3:0] eflags);
        vec_t t;
        t.v0 = v0; t.c0 = c0; t.a0 = a0; t.b0 = b0;
        t.v1 = v1; t.c1 = c1; t.a1 = a1; t.b1 = b1;
        t.er0 = er0; t.er1 = er1; t.eres = eres; t.eflg = eflg;
        t.eerr = eerr; t.eflags = eflags;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] c0, input logic [W-1:0] a0,
                         input logic [W-1:0] b0, input logic v1, input logic [3:0] c1,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rdy);
        req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1;
        rsp_ready  = rdy;
    endtask

    // Called #1 before the edge: compare readys and queue the expected response.
    task automatic pre_edge(input logic er0, input logic er1, input logic [W-1:0] eres,
                            input logic [3:0] eflg, input logic eerr);
        rsp_t r;
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, er0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, er1});
        if (er0 || er1) begin
            r.id = er1; r.res = eres; r.flg = eflg; r.err = eerr;
            sb.push_back(r);
        end
    endtask

    // Called #1 after the edge: pop and compare if an accept was expected.
    task automatic post_edge(input logic accepted, input logic exp_valid);
        rsp_t r;
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_valid});
        if (accepted) begin
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 64'd0, 64'd1);
            end else begin
                r = sb.pop_front();
                chk("rsp_id", {63'd0, rsp_id}, {63'd0, r.id});
                chk("rsp_result", rsp_result, r.res);
                chk("rsp_flags", {60'd0, rsp_flags}, {60'd0, r.flg});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, r.err});
                n_txn++;
                $display("txn %0d: id=%0d result=%0h flags=%b err=%0d arch_flags=%b",
                         n_txn, rsp_id, rsp_result, rsp_flags, rsp_err, flags);
            end
        end
    endtask

    localparam logic [W-1:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINNEG = 64'h8000_0000_0000_0000;

    initial begin
        logic [W-1:0] held_res;
        // ready0 ready1 result rsp_flags err flags_after; rsp_ready=1 throughout
        vecs[0]  = mk(1, 4'b0010, 5, 7,        0, 4'b0000, 0, 0,        1, 0, 12, 4'b0000, 0, 4'b0000);
        vecs[1]  = mk(0, 4'b0000, 0, 0,        1, 4'b1110, 3, 3,        0, 1, 0,  4'b0100, 0, 4'b0100);
        vecs[2]  = mk(1, 4'b0010, 1, 2,        0, 4'b0000, 0, 0,        1, 0, 3,  4'b0000, 0, 4'b0100);
        vecs[3]  = mk(1, 4'b0001, 'hF0, 'h0F,  1, 4'b0000, 'hFF, 'h3C,  0, 1, 'h3C, 4'b0000, 0, 4'b0100);
        vecs[4]  = mk(1, 4'b0001, 'hF0, 'h0F,  1, 4'b0111, 0, MINNEG,   1, 0, 'hFF, 4'b0000, 0, 4'b0100);
        vecs[5]  = mk(1, 4'b1010, MAXPOS, 1,   1, 4'b0111, 0, MINNEG,   0, 1, MINNEG, 4'b1000, 0, 4'b0100);
        vecs[6]  = mk(1, 4'b1010, MAXPOS, 1,   0, 4'b0000, 0, 0,        1, 0, MINNEG, 4'b1001, 0, 4'b1001);
        vecs[7]  = mk(0, 4'b0000, 0, 0,        1, 4'b1000, 9, 4,        0, 1, 0,  4'b0100, 1, 4'b1001);
        vecs[8]  = mk(1, 4'b1110, 2, 5,        0, 4'b0000, 0, 0,        1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 4'b1010, 0, 4'b1010);
        vecs[9]  = mk(0, 4'b0000, 0, 0,        1, 4'b1011, 0, 0,        0, 1, 0,  4'b0100, 1, 4'b1010);
        vecs[10] = mk(0, 4'b0000, 0, 0,        0, 4'b0000, 0, 0,        0, 0, 0,  4'b0000, 0, 4'b1010);

        // Reset state
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_flags", {60'd0, flags}, 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0,
                  vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1, 1'b1);
            #1;
            pre_edge(vecs[i].er0, vecs[i].er1, vecs[i].eres, vecs[i].eflg, vecs[i].eerr);
            @(posedge clk); #1;
            post_edge(vecs[i].er0 | vecs[i].er1, vecs[i].er0 | vecs[i].er1);
            chk("arch_flags", {60'd0, flags}, {60'd0, vecs[i].eflags});
        end

        // Round-robin after a fresh reset: 0,1,0,1,0,1 with one response per cycle
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1, 4'b0010, 1, 1, 1, 4'b0010, 2, 2, 1'b1);
            #1;
            pre_edge(i % 2 == 0, i % 2 == 1, (i % 2 == 0) ? 64'd2 : 64'd4, 4'b0000, 1'b0);
            @(posedge clk); #1;
            post_edge(1'b1, 1'b1);
        end

        // Backpressure: load a response (r0, last grant was r1), then stall 3 cycles
        @(negedge clk);
        drive(1, 4'b0010, 1, 1, 1, 4'b0010, 2, 2, 1'b1);
        #1;
        pre_edge(1'b1, 1'b0, 64'd2, 4'b0000, 1'b0);
        @(posedge clk); #1;
        post_edge(1'b1, 1'b1);
        held_res = rsp_result;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            pre_edge(1'b0, 1'b0, 64'd0, 4'b0000, 1'b0);
            @(posedge clk); #1;
            post_edge(1'b0, 1'b1);
            chk("stall_rsp_id", {63'd0, rsp_id}, 64'd0);
            chk("stall_rsp_result", rsp_result, 64'd2);
        end
        // Raise rsp_ready: pending r1 accepted in the same cycle
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        pre_edge(1'b0, 1'b1, 64'd4, 4'b0000, 1'b0);
        @(posedge clk); #1;
        post_edge(1'b1, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        @(posedge clk); #1;
        post_edge(1'b0, 1'b0);

        // Async reset while FULL with flags=1001
        @(negedge clk);
        drive(1, 4'b1010, MAXPOS, 1, 0, 0, 0, 0, 1'b0);
        #1;
        pre_edge(1'b1, 1'b0, MINNEG, 4'b1001, 1'b0);
        @(posedge clk); #1;
        post_edge(1'b1, 1'b1);
        chk("pre_reset_flags", {60'd0, flags}, 64'h9);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("async_flags", {60'd0, flags}, 64'd0);
        chk("async_rsp_result", rsp_result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 4'b0010, 5, 7, 1, 4'b0010, 1, 1, 1'b1);
        #1;
        pre_edge(1'b1, 1'b0, 64'd12, 4'b0000, 1'b0);
        @(posedge clk); #1;
        post_edge(1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 64-bit ALU. It picks one operation per cycle from two valid/ready requesters using round-robin priority, drives the ALU operands and control code, and captures the result in a one-deep output register with backpressure. It also owns the architectural NZCV flags register, which only flag-setting operations update.

## Interface
Parameters:
- W, 64, operand/result width; must match the ALU width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid, req1_valid  in  1  request valid per requester
- req0_ready, req1_ready  out  1  request accepted this cycle
- req0_a, req0_b, req1_a, req1_b  in  W  operands
- req0_ctrl, req1_ctrl  in  4  ALU control code
- alu_a, alu_b  out  W  operands to the ALU
- alu_ctrl  out  4  control code to the ALU
- alu_result  in  W  ALU result (combinational)
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flag outputs
- rsp_valid  out  1  response register full
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that issued the response
- rsp_result  out  W  registered result
- rsp_flags  out  4  {N,Z,C,V} produced by that operation
- rsp_err  out  1  control code was illegal
- flags  out  4  architectural {N,Z,C,V} register

## Operation
- Legal codes: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 MOV (pass b), 1010 ADDS, 1110 SUBS. All other codes are illegal.
- can_accept = !rsp_valid || rsp_ready.
- Grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - last_grant resets to 1, so r0 wins the first tie.
  - last_grant updates only on an actual accept.
- reqN_ready = grantN && can_accept. At most one ready is high per cycle.
- reqN_ready depends on both valids and on rsp_ready, not on the payload.
- alu_a/alu_b/alu_ctrl mux the granted requester's payload. With no grant they drive r0's payload; these values are don't-care.
- On accept, the response register loads:
  - rsp_result = alu_result
  - rsp_flags = {alu_n, alu_z, alu_c, alu_v}
  - rsp_id = granted index
  - rsp_err = illegal code
  - rsp_valid = 1
- Illegal code: the operation is still accepted and the response is issued. rsp_err=1 and rsp_result is whatever the ALU returns (0 for undefined codes).
- The flags register loads {alu_n, alu_z, alu_c, alu_v} on accept only if the code is 1010 or 1110. Otherwise it holds, including for illegal codes with bit 3 set.
- Response register states:
  - EMPTY→FULL on accept.
  - FULL→EMPTY when rsp_ready is high and there is no new accept.
  - FULL→FULL, reloaded, when rsp_ready and an accept occur in the same cycle.
  - FULL holds all rsp_* outputs stable while rsp_ready=0.
- Requester protocol: a requester keeps valid and its payload stable until it sees ready. The arbiter does not check this.

## Timing
- Reset (asynchronous assert, synchronous release): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, flags=0000, last_grant=1.
- Reset mid-operation drops any in-flight response. No accept occurs in the first cycle after reset release unless a req is valid.
- Latency: an accept at edge N makes the response visible after edge N, so rsp_valid=1 in cycle N+1.
- flags updates at the same edge as the accept.
- Throughput: one operation per cycle while rsp_ready=1.
- Zero-bubble: with FULL and rsp_ready=1, a new accept happens in the same cycle.
- Flag ordering: the flags from operation k are visible to operation k+1 accepted in the next cycle, because there is no forwarding inside the block.

## Test plan
- ADD with no contention: r0 a=5, b=7, ctrl=0010, rsp_ready=1 → req0_ready=1 that cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_err=0, flags stays 0000.
- SUBS sets Z: r1 a=3, b=3, ctrl=1110 → rsp_result=0, rsp_flags Z=1, rsp_id=1. flags becomes 0100 after the accept edge. A following ADD leaves flags at 0100.
- Round-robin: both requesters valid every cycle, rsp_ready=1, after reset → accepts alternate r0,r1,r0,r1. rsp_id follows the same sequence one cycle later, one response per cycle.
- Backpressure: with response FULL, drop rsp_ready for 3 cycles → both readys=0 and rsp_* stable for all 3 cycles. When rsp_ready is raised, the pending request is accepted that same cycle and the new response appears next cycle.
- Illegal code: ctrl=1000, a=9, b=4 → rsp_err=1, rsp_result=0, flags unchanged.
- Reset while rsp_valid=1 and flags=1001 → rsp_valid=0 and flags=0000 immediately, with no clock edge required. After release, with both requesters valid, r0 is granted first.
